// File: rtl/cycle_mon_pkg.sv
// rtl/cycle_mon_pkg.sv - shared types, constants and adder for the cycle offset monitor
// Optional feature macro: CYCLE_MON_SATURATE_EN (saturating adders instead of wrap).
package cycle_mon_pkg;

    localparam int DATA_W  = 32;
    localparam int LATENCY = 3;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EVAL_A  = 2'd2,
        ST_EVAL_BC = 2'd3
    } state_t;

    localparam data_t DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam data_t DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic data_t stream_add(input data_t lhs, input data_t rhs);
        data_t sum;
        sum = lhs + rhs;
`ifdef CYCLE_MON_SATURATE_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((lhs[DATA_W-1] == rhs[DATA_W-1]) && (sum[DATA_W-1] != lhs[DATA_W-1])) begin
            sum = lhs[DATA_W-1] ? DATA_MIN : DATA_MAX;
        end
`else
        sum = lhs + rhs;
`endif
        return sum;
    endfunction

endpackage

// File: rtl/stream_history.sv
// rtl/stream_history.sv - past-value registers a[n-1], a[n-2] and b[n-1]
// Shifts only when an evaluation completes; asynchronous active-low reset.
module stream_history
    import cycle_mon_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_prev1,
    output logic signed [DATA_W-1:0] a_prev2,
    output logic signed [DATA_W-1:0] b_prev1
);

    data_t a1_q, a1_d;
    data_t a2_q, a2_d;
    data_t b1_q, b1_d;

    always_comb begin
        a1_d = a1_q;
        a2_d = a2_q;
        b1_d = b1_q;
        if (shift_en) begin
            a1_d = a_in;
            a2_d = a1_q;
            b1_d = b_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q <= '0;
            a2_q <= '0;
            b1_q <= '0;
        end else begin
            a1_q <= a1_d;
            a2_q <= a2_d;
            b1_q <= b1_d;
        end
    end

    assign a_prev1 = a1_q;
    assign a_prev2 = a2_q;
    assign b_prev1 = b1_q;

endmodule

// File: rtl/cycle_offset_monitor.sv
// rtl/cycle_offset_monitor.sv - stream monitor core: a = x + b', b = a', c = (a + b, a'')
// Optional feature macro: CYCLE_MON_SATURATE_EN (handled inside cycle_mon_pkg::stream_add).
module cycle_offset_monitor
    import cycle_mon_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     newX,
    output logic signed [DATA_W-1:0] result_0,
    output logic signed [DATA_W-1:0] result_1,
    output logic signed [DATA_W-1:0] result_2_0,
    output logic signed [DATA_W-1:0] result_2_1
);

    state_t state_q, state_d;

    logic capture_en;
    logic eval_a_en;
    logic eval_bc_en;

    data_t x_q, x_d;
    data_t a_calc_q, a_calc_d;
    data_t res_a_q, res_a_d;
    data_t res_b_q, res_b_d;
    data_t res_c0_q, res_c0_d;
    data_t res_c1_q, res_c1_d;

    data_t hist_a1;
    data_t hist_a2;
    data_t hist_b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_IDLE:    if (newX) state_d = ST_CAPTURE;
                ST_CAPTURE: state_d = ST_EVAL_A;
                ST_EVAL_A:  state_d = ST_EVAL_BC;
                ST_EVAL_BC: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // x is only valid alongside newX, so it is latched on the accepting edge itself.
    always_comb begin
        capture_en = 1'b0;
        eval_a_en  = 1'b0;
        eval_bc_en = 1'b0;
        if (en) begin
            capture_en = (state_q == ST_IDLE) && newX;
            eval_a_en  = (state_q == ST_EVAL_A);
            eval_bc_en = (state_q == ST_EVAL_BC);
        end
    end

    always_comb begin
        x_d      = x_q;
        a_calc_d = a_calc_q;
        res_a_d  = res_a_q;
        res_b_d  = res_b_q;
        res_c0_d = res_c0_q;
        res_c1_d = res_c1_q;
        if (capture_en) begin
            x_d = x;
        end
        if (eval_a_en) begin
            a_calc_d = stream_add(x_q, hist_b1);
        end
        if (eval_bc_en) begin
            res_a_d  = a_calc_q;
            res_b_d  = hist_a1;
            res_c0_d = stream_add(a_calc_q, hist_a1);
            res_c1_d = hist_a2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            a_calc_q <= '0;
            res_a_q  <= '0;
            res_b_q  <= '0;
            res_c0_q <= '0;
            res_c1_q <= '0;
        end else begin
            x_q      <= x_d;
            a_calc_q <= a_calc_d;
            res_a_q  <= res_a_d;
            res_b_q  <= res_b_d;
            res_c0_q <= res_c0_d;
            res_c1_q <= res_c1_d;
        end
    end

    stream_history u_history (
        .clk      (clk),
        .rst_n    (rst),
        .shift_en (eval_bc_en),
        .a_in     (a_calc_q),
        .b_in     (hist_a1),
        .a_prev1  (hist_a1),
        .a_prev2  (hist_a2),
        .b_prev1  (hist_b1)
    );

    assign result_0   = res_a_q;
    assign result_1   = res_b_q;
    assign result_2_0 = res_c0_q;
    assign result_2_1 = res_c1_q;

endmodule

// File: tb/tb_cycle_offset_monitor.sv
// tb/tb_cycle_offset_monitor.sv - directed self-checking bench for cycle_offset_monitor
module tb_cycle_offset_monitor;
    import cycle_mon_pkg::*;

    logic  clk;
    logic  rst;
    logic  en;
    data_t x;
    logic  newX;
    data_t result_0;
    data_t result_1;
    data_t result_2_0;
    data_t result_2_1;

    int checks;
    int errors;

    cycle_offset_monitor topEntity (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x          (x),
        .newX       (newX),
        .result_0   (result_0),
        .result_1   (result_1),
        .result_2_0 (result_2_0),
        .result_2_1 (result_2_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input data_t got, input data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input data_t ea, input data_t eb,
                             input data_t ec0, input data_t ec1);
        check_val($sformatf("%s.a", tag),   result_0,   ea);
        check_val($sformatf("%s.b", tag),   result_1,   eb);
        check_val($sformatf("%s.c0", tag),  result_2_0, ec0);
        check_val($sformatf("%s.c1", tag),  result_2_1, ec1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge after the outputs update.
    task automatic send_event(input data_t v);
        x    = v;
        newX = 1'b1;
        @(negedge clk);
        newX = 1'b0;
        repeat (LATENCY) @(negedge clk);
    endtask

    data_t exp_a  [6] = '{1, 2, 4, 6, 9, 12};
    data_t exp_b  [6] = '{0, 1, 2, 4, 6, 9};
    data_t exp_c0 [6] = '{1, 3, 6, 10, 15, 21};
    data_t exp_c1 [6] = '{0, 0, 1, 2, 4, 6};
    data_t big;
    data_t exp_ovf;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        en     = 1'b1;
        newX   = 1'b0;
        x      = '0;
        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);

        // Latency of the first event, then the 50 us spaced sequence
        x    = 1;
        newX = 1'b1;
        @(negedge clk);
        newX = 1'b0;
        @(negedge clk);
        check_val("lat_edge1.a", result_0, 0);
        @(negedge clk);
        check_val("lat_edge2.a", result_0, 0);
        check_val("lat_edge2.c0", result_2_0, 0);
        @(negedge clk);
        check_out("seq_x1", exp_a[0], exp_b[0], exp_c0[0], exp_c1[0]);
        repeat (4996) @(negedge clk);
        for (int i = 1; i < 6; i++) begin
            send_event(data_t'(i + 1));
            check_out($sformatf("seq_x%0d", i + 1), exp_a[i], exp_b[i], exp_c0[i], exp_c1[i]);
            repeat (4996) @(negedge clk);
        end

        // Busy drop: second pulse one cycle after acceptance is ignored
        do_reset();
        x    = 1;
        newX = 1'b1;
        @(negedge clk);
        x    = 100;
        newX = 1'b1;
        @(negedge clk);
        newX = 1'b0;
        x    = 0;
        repeat (2) @(negedge clk);
        check_out("busy_x1", 1, 0, 1, 0);
        repeat (3) @(negedge clk);
        check_out("busy_idle", 1, 0, 1, 0);
        send_event(2);
        check_out("busy_x2", 2, 1, 3, 0);

        // Enable hold during EVAL_A
        do_reset();
        x    = 5;
        newX = 1'b1;
        @(negedge clk);
        newX = 1'b0;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x    = 99;
            newX = (i == 1);
            @(negedge clk);
            check_val($sformatf("hold%0d.a", i), result_0, 0);
        end
        newX = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        check_val("hold_late.a", result_0, 0);
        @(negedge clk);
        check_out("hold_x5", 5, 0, 5, 0);
        send_event(1);
        check_out("hold_next", 1, 5, 6, 0);

        // Asynchronous reset in the middle of EVAL_BC
        do_reset();
        send_event(1);
        send_event(2);
        send_event(3);
        check_out("mid_x3", 4, 2, 6, 1);
        x    = 4;
        newX = 1'b1;
        @(negedge clk);
        newX = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_out("mid_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_event(7);
        check_out("mid_x7", 7, 0, 7, 0);

        // Overflow with b[n-1] = a[n-2] = 1
        do_reset();
        send_event(1);
        send_event(0);
        check_out("ovf_pre", 0, 1, 1, 0);
        big = 32'sh7FFF_FFFF;
`ifdef CYCLE_MON_SATURATE_EN
        exp_ovf = 32'sh7FFF_FFFF;
`else
        exp_ovf = 32'sh8000_0000;
`endif
        send_event(big);
        check_out("ovf", exp_ovf, 0, exp_ovf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_offset_monitor.md
# cycle_offset_monitor

Hardware stream monitor for a recursive specification with multi-step offsets. Each `newX` event samples a signed input `x` and evaluates three dependent output streams: `a`, `b` and the tuple `c`. The streams are coupled through past-value references with default 0. The block is the top-level monitor core, instantiated as `topEntity`, clocked by the system 100 MHz clock; its outputs are read directly by the surrounding logic.

## Interface
- `DATA_W`, default 32: width of all stream values, signed two's complement.
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: clock enable; when 0, all state holds.
- `x` input, `DATA_W` bits: input stream value, signed.
- `newX` input, 1 bit: event strobe; `x` is valid in the same cycle.
- `result_0` output, `DATA_W` bits: stream `a`.
- `result_1` output, `DATA_W` bits: stream `b`.
- `result_2_0` output, `DATA_W` bits: stream `c.0`.
- `result_2_1` output, `DATA_W` bits: stream `c.1`.

## Operation
- Event n is accepted when a rising edge sees `en` = 1, `newX` = 1, and the block is idle.
- The evaluation equations are:
  - a[n] = x[n] + b[n-1]
  - b[n] = a[n-1]
  - c.0[n] = a[n] + b[n]
  - c.1[n] = a[n-2]
- Any missing history (n-1 or n-2 before the first event) defaults to 0.
- History registers: a[n-1], a[n-2] and b[n-1]. They shift only on completion of an event.
- Arithmetic: `DATA_W`-bit signed, wrap-around on overflow. See Configuration for the saturating alternative.
- Outputs hold their last value between events.
- Pipeline FSM states: IDLE → CAPTURE → EVAL_A → EVAL_BC → IDLE.
  - CAPTURE registers `x`.
  - EVAL_A computes `a`.
  - EVAL_BC computes `b` and `c`, updates the outputs and shifts the history.
- A `newX` pulse arriving while the FSM is not in IDLE is dropped; history is unaffected.
- `en` = 0 freezes the FSM, history and outputs in place; `newX` is ignored in that cycle.
- Reset asserted: all outputs, history and the captured `x` go to 0, and the FSM goes to IDLE.
  - This is asynchronous, even in the middle of an evaluation.
  - The partial evaluation is discarded.

## Timing
- Outputs update on the 3rd enabled rising edge after the accepting edge.
- All four outputs update on the same edge.
- Throughput: one event per 4 enabled cycles.
- A `newX` pulse only 1 cycle wide must be captured.
- No combinational path from inputs to outputs.

## Configuration
- `CYCLE_MON_SATURATE_EN` defined: the adders saturate to the signed min/max of `DATA_W` instead of wrapping.
- `CYCLE_MON_SATURATE_EN` undefined: the adders use plain two's-complement wrap.

## Structure
- Package `cycle_mon_pkg` holds:
  - `DATA_W`
  - the `data_t` signed typedef
  - the FSM state enum
  - the `LATENCY` = 3 constant
- Sub-module `stream_history`: shift register for a[n-1] and a[n-2], plus the b[n-1] register, with shift enable and async reset.

## Test plan
- Reset, then events x = 1, 2, 3, 4, 5, 6, each 1-cycle `newX`, spaced 50 µs apart. Results after each event, given as (a, b, c.0, c.1):
  - after x = 1: (1, 0, 1, 0)
  - after x = 2: (2, 1, 3, 0)
  - after x = 3: (4, 2, 6, 1)
  - after x = 4: (6, 4, 10, 2)
  - after x = 5: (9, 6, 15, 4)
  - after x = 6: (12, 9, 21, 6)
- Latency: event x = 1 after reset; outputs stay 0 for 2 edges, then become (1, 0, 1, 0) on the 3rd edge.
- Busy drop: x = 1 accepted, then `newX` pulsed with x = 100 one cycle later.
  - Result is (1, 0, 1, 0); the next event x = 2 yields (2, 1, 3, 0).
- Enable hold: drop `en` during EVAL_A for 5 cycles.
  - Outputs are unchanged during the hold.
  - The result appears 5 cycles late with correct values.
  - A `newX` pulse while `en` = 0 is ignored.
- Mid-operation reset: assert `rst` low during EVAL_BC after 3 events.
  - All outputs go to 0 immediately.
  - The next event x = 7 yields (7, 0, 7, 0).
- Overflow: event x = 2^31 - 1 after history a[n-2] = 1. Expected `a`:
  - wrap build: -2^31
  - `CYCLE_MON_SATURATE_EN` build: 2^31 - 1
